// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor d = a - b, one bit per clock, LSB
// first, with a registered borrow and a start/done handshake.
// Ports: clk, rst (sync, active-high), start, a, b -> busy, done, d, bout,
//        and ovf (signed overflow) only when SUB_OVF_EN is defined.
// Config macro: SUB_OVF_EN adds the ovf port and the sign-capture flops.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
`ifdef SUB_OVF_EN
    output logic             bout,
    output logic             ovf
`else
    output logic             bout
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_d;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;
    logic             r_bout;
    logic             w_diff;
    logic             w_bnext;
    logic [WIDTH-1:0] w_res_next;
    logic             w_last;

`ifdef SUB_OVF_EN
    logic r_sa;
    logic r_sb;
    logic r_ovf;
`endif

    always_comb begin
        w_diff     = r_ra[0] ^ r_rb[0] ^ r_borrow;
        w_bnext    = (~r_ra[0] & r_rb[0]) |
                     (~(r_ra[0] ^ r_rb[0]) & r_borrow);
        w_res_next = {w_diff, r_res[WIDTH-1:1]};
        w_last     = (r_cnt == LAST);
        w_next     = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SHIFT;
            SHIFT:   if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ra     <= '0;
            r_rb     <= '0;
            r_res    <= '0;
            r_d      <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
`ifdef SUB_OVF_EN
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_ovf    <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_ra     <= a;
                        r_rb     <= b;
                        r_cnt    <= '0;
                        r_borrow <= 1'b0;
`ifdef SUB_OVF_EN
                        r_sa     <= a[WIDTH-1];
                        r_sb     <= b[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    r_ra     <= {1'b0, r_ra[WIDTH-1:1]};
                    r_rb     <= {1'b0, r_rb[WIDTH-1:1]};
                    r_res    <= w_res_next;
                    r_borrow <= w_bnext;
                    r_cnt    <= r_cnt + 1'b1;
                    // Results publish only on entry to DONE and then hold.
                    if (w_last) begin
                        r_d    <= w_res_next;
                        r_bout <= w_bnext;
`ifdef SUB_OVF_EN
                        r_ovf  <= (r_sa != r_sb) && (w_diff != r_sa);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);
    assign d    = r_d;
    assign bout = r_bout;
`ifdef SUB_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
// Covers reset, latency, ignored starts, abort and random ops.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;
`ifdef SUB_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .d     (d),
`ifdef SUB_OVF_EN
        .bout  (bout),
        .ovf   (ovf)
`else
        .bout  (bout)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start an op, scramble a/b after accept, wait for done, check result.
    task automatic run_op(input string tag, input logic [W-1:0] va,
                          input logic [W-1:0] vb, input logic [W-1:0] ed,
                          input logic eb, input logic eo);
        int n;
        a = va;
        b = vb;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = ~va;
        b = va ^ vb;
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(W));
        chk({tag, "_d"}, 64'(d), 64'(ed));
        chk({tag, "_bout"}, 64'(bout), 64'(eb));
`ifdef SUB_OVF_EN
        chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
`else
        if (eo === 1'bx) chk({tag, "_eo"}, 64'(0), 64'(1));
`endif
        tick();
        chk({tag, "_onepulse"}, 64'(done), 64'(0));
        chk({tag, "_idle"}, 64'(busy), 64'(0));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] rd;
        logic         ro;
        int           n;
        int           seen;

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_d", 64'(d), 64'(0));
        chk("rst_bout", 64'(bout), 64'(0));
`ifdef SUB_OVF_EN
        chk("rst_ovf", 64'(ovf), 64'(0));
`endif
        rst = 1'b0;
        tick();

        run_op("t05m03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run_op("t03m05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        run_op("tFFmFF", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
        run_op("t80m01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op("t7FmFF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
        run_op("t10m01", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);

        // Starts while busy are ignored, including in the DONE cycle.
        a = 8'h05;
        b = 8'h03;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("hold_d", 64'(d), 64'(8'h0F));
        n = 0;
        while (!done && n < 40) begin
            start = (n == 3);
            a = 8'hAA;
            b = 8'h11;
            tick();
            n++;
        end
        start = 1'b0;
        chk("ign_lat", 64'(n), 64'(W));
        chk("ign_d", 64'(d), 64'(8'h02));
        chk("ign_bout", 64'(bout), 64'(0));
        start = 1'b1;
        tick();
        chk("ign_done_cycle", 64'(busy), 64'(0));
        tick();
        start = 1'b0;
        chk("after_done_acc", 64'(busy), 64'(1));
        chk("after_done_hold", 64'(d), 64'(8'h02));
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk("acc_lat", 64'(n), 64'(W));
        chk("acc_d", 64'(d), 64'(8'h99));
        chk("acc_bout", 64'(bout), 64'(0));
        tick();

        // Abort mid-operation.
        a = 8'h03;
        b = 8'h05;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_d", 64'(d), 64'(0));
        chk("abort_bout", 64'(bout), 64'(0));
        seen = 0;
        repeat (12) begin
            if (done) seen++;
            tick();
        end
        chk("abort_nodone", 64'(seen), 64'(0));

        // Reset beats start in the same cycle.
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        chk("rst_prio", 64'(busy), 64'(0));

        for (int i = 0; i < 300; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rd = ra - rb;
            ro = (ra[W-1] != rb[W-1]) && (rd[W-1] != ra[W-1]);
            run_op("rnd", ra, rb, rd, ra < rb, ro);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
